mips_lsu: RTL and testbench
===========================

Name: mips_lsu

Overview:
Load/store unit that acts as the initiator side of the data-memory interface. It drives the word-wide data RAM: combinational read, word write on posedge clk when we=1, word index addr[31:2].
- Accepts byte, halfword and word load/store requests from the core through a valid/ready handshake.
- Performs alignment checks, byte-lane extraction and sign/zero extension.
- Implements sub-word stores as read-modify-write, because the RAM only writes whole words.

Parameters:
ADDR_W, 32, byte address width on request and memory sides
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data, right-justified
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  load result (0 for stores and errors)
resp_err  output  1  misaligned or reserved-size request; valid with resp_valid
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_W  RAM byte address, always word-aligned (low 2 bits 0)
mem_din  output  DATA_W  RAM write data
mem_dout  input  DATA_W  RAM combinational read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_addr=0; mem_din=0. All request registers are cleared.
- Reset mid-transaction aborts immediately. mem_we drops asynchronously, so no RAM write occurs on the next edge.
- Accept: a request is accepted on a rising edge with req_valid&&req_ready. The request is captured into registers; inputs are ignored until the FSM returns to IDLE.
- Byte lanes are little-endian: offset 0 is bits 7:0, offset 3 is bits 31:24. A halfword at offset 2 is bits 31:16.
- Error detection at accept:
  - size=11 is an error.
  - A half with addr[0]=1 is an error.
  - A word with addr[1:0]!=0 is an error.
  - On error the FSM goes IDLE->RESP with no memory access and resp_err=1.
- States and transitions:
  - IDLE: req_ready=1. On accept go to ERR-RESP, ACCESS, or READ.
  - ACCESS:
    - Drives mem_addr={addr[31:2],2'b00}.
    - Load: mem_we=0; the extracted/extended lane is registered into resp_rdata. Next state RESP.
    - Word store: mem_we=1, mem_din=wdata. Next state RESP.
  - READ (sub-word store only): mem_we=0. Registers mem_dout merged with wdata into the addressed lane(s). Next state WRITE.
  - WRITE: mem_we=1, mem_din=merged word, same mem_addr. Next state RESP.
  - RESP: resp_valid=1 for exactly one cycle. Next state IDLE.
- Latency, counted from accept edge to the cycle resp_valid is high:
  - Load and word store: 2.
  - Sub-word store: 3.
  - Error: 1.
  - Throughput is at most one request per 3 (or 4) cycles; there is no response backpressure.
- mem_we is high only in ACCESS (word store) or WRITE; it is 0 in every other state.
- Load extension: byte signed replicates bit 7; half signed replicates bit 15; unsigned zero-fills. req_signed is ignored for word loads and for stores.
- Store data: only the low 8/16 bits of req_wdata are used for byte/half stores.
- resp_rdata is held until the next response, then cleared to 0 for store and error responses.
- An address wrap at 0xFFFFFFFC is not special; only the word index is used.

Optional Feature:
LSU_TRACE_EN
- Defined: each RESP cycle issues a $display of the form "INFO: LSU <LD|ST> size=<n> addr=0x%08X data=0x%08X err=<0|1>". A misaligned request additionally prints "WARNING: LSU misaligned addr %08X".
- Undefined: no display statements; RTL is otherwise identical, cycle for cycle.

Decomposition:
- Package mips_lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state enum (IDLE, ACCESS, READ, WRITE, RESP);
  - lane-width constants.
- Sub-module lsu_lane is purely combinational. It extracts and extends on load, and merges on store, given offset, size and signed.
- The FSM and registers live in mips_lsu.

Test Plan:
- RAM word 4 (addr 0x10) =0x80FF7F01. Byte signed load @0x12 -> rdata 0xFFFFFFFF, 2 cycles, err=0. Half unsigned @0x12 -> 0x000080FF. Half signed -> 0xFFFF80FF.
- Word store 0xDEADBEEF @0x20 -> mem_we high exactly 1 cycle, mem_addr=0x20. A subsequent word load @0x20 returns 0xDEADBEEF.
- Word @0x30 =0x11223344. Byte store 0xAB @0x31 -> READ then WRITE; mem_din=0x1122AB44; resp 3 cycles after accept.
- Half load @0x13 and word store @0x22 -> resp_err=1 after 1 cycle; mem_we never asserts; RAM unchanged.
- Assert rst_n=0 during the WRITE state of a half store -> mem_we falls immediately, target word is unchanged, req_ready=1 after release.
- Back-to-back req_valid held high -> req_ready is low outside IDLE; exactly one resp_valid per accepted request, in order.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// rtl/mips_lsu_pkg.sv - shared encodings, lane widths and FSM states for the load/store unit
package mips_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } state_e;

    // Reserved size or an access not aligned to its own width.
    function automatic logic req_error(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: req_error = 1'b0;
            SZ_HALF: req_error = off[0];
            SZ_WORD: req_error = (off != 2'b00);
            default: req_error = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane
    import mips_lsu_pkg::*;
(
    input  logic [1:0]        offset_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_o,
    output logic [WORD_W-1:0] merge_o
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    always_comb begin
        byte_lane = word_i[{offset_i, 3'b000} +: BYTE_W];
        half_lane = offset_i[1] ? word_i[31:16] : word_i[15:0];
        load_o    = word_i;
        merge_o   = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o  = {{(WORD_W-BYTE_W){signed_i & byte_lane[BYTE_W-1]}}, byte_lane};
                merge_o = word_i;
                merge_o[{offset_i, 3'b000} +: BYTE_W] = wdata_i[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_o  = {{(WORD_W-HALF_W){signed_i & half_lane[HALF_W-1]}}, half_lane};
                merge_o = word_i;
                merge_o[{offset_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// rtl/mips_lsu.sv - load/store unit FSM driving a word-wide RAM, sub-word stores via read-modify-write
// Optional LSU_TRACE_EN: prints one trace line per response.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] merged_q, merged_d;
    logic [DATA_W-1:0] lane_load, lane_merge;

    lsu_lane u_lane (
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .word_i   (mem_dout),
        .wdata_i  (wdata_q),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        merged_d = merged_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = req_error(req_size, req_addr[1:0]);
                    if (err_d) begin
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (req_we && req_size != SZ_WORD) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                rdata_d = we_q ? '0 : lane_load;
                state_d = ST_RESP;
            end
            ST_READ: begin
                merged_d = lane_merge;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                rdata_d = '0;
                state_d = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            merged_q <= merged_d;
        end
    end

    // Write enable decodes straight from state so an async reset kills it at once.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign mem_we     = ((state_q == ST_ACCESS) && we_q) || (state_q == ST_WRITE);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_din    = (state_q == ST_WRITE) ? merged_q : wdata_q;

`ifdef LSU_TRACE_EN
    always @(posedge clk) begin
        if (state_q == ST_RESP) begin
            $display("INFO: LSU %s size=%0d addr=0x%08X data=0x%08X err=%0d",
                     we_q ? "ST" : "LD", size_q, addr_q, we_q ? wdata_q : rdata_q, err_q);
            if (err_q && size_q != 2'b11)
                $display("WARNING: LSU misaligned addr %08X", addr_q);
        end
    end
`endif

endmodule

// File: tb/tb_mips_lsu.sv
// tb/tb_mips_lsu.sv - directed self-checking bench for mips_lsu with a behavioural word RAM
module tb_mips_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:63];

    int total = 0;
    int bad = 0;

    int          r_lat;
    int          r_wecnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_waddr;
    logic [31:0] r_wdin;
    int          nresp;

    always #5 clk = ~clk;

    mips_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    assign mem_dout = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        logic got;
        @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        got = 1'b0;
        r_lat = 99; r_wecnt = 0; r_rdata = 'x; r_err = 1'bx; r_waddr = 'x; r_wdin = 'x;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mem_we) begin
                r_wecnt++;
                r_waddr = mem_addr;
                r_wdin  = mem_din;
            end
            if (resp_valid) begin
                got = 1'b1;
                r_lat = c;
                r_rdata = resp_rdata;
                r_err = resp_err;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[4]  = 32'h80FF7F01;
        ram[12] = 32'h11223344;
        ram[16] = 32'h55667788;

        #2;
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        chk("lb_s_12_data", r_rdata, 32'hFFFFFFFF);
        chk("lb_s_12_lat", r_lat, 2);
        chk("lb_s_12_err", {31'b0, r_err}, 32'd0);
        chk("lb_s_12_we", r_wecnt, 0);

        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        chk("lh_u_12_data", r_rdata, 32'h000080FF);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        chk("lh_s_12_data", r_rdata, 32'hFFFF80FF);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        chk("lb_u_11_data", r_rdata, 32'h0000007F);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        chk("lb_s_13_data", r_rdata, 32'hFFFFFF80);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        chk("lh_s_10_data", r_rdata, 32'h00007F01);

        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        chk("sw_20_lat", r_lat, 2);
        chk("sw_20_wecnt", r_wecnt, 1);
        chk("sw_20_waddr", r_waddr, 32'h20);
        chk("sw_20_rdata", r_rdata, 32'h0);
        chk("sw_20_ram", ram[8], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b1, 32'h20, 32'h0);
        chk("lw_20_data", r_rdata, 32'hDEADBEEF);

        do_req(1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAB);
        chk("sb_31_lat", r_lat, 3);
        chk("sb_31_wecnt", r_wecnt, 1);
        chk("sb_31_waddr", r_waddr, 32'h30);
        chk("sb_31_wdin", r_wdin, 32'h1122AB44);
        chk("sb_31_rdata", r_rdata, 32'h0);
        chk("sb_31_ram", ram[12], 32'h1122AB44);

        do_req(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000CAFE);
        chk("sh_32_lat", r_lat, 3);
        chk("sh_32_ram", ram[12], 32'hCAFEAB44);

        do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        chk("lh_13_err", {31'b0, r_err}, 32'd1);
        chk("lh_13_lat", r_lat, 1);
        chk("lh_13_wecnt", r_wecnt, 0);
        chk("lh_13_rdata", r_rdata, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678);
        chk("sw_22_err", {31'b0, r_err}, 32'd1);
        chk("sw_22_lat", r_lat, 1);
        chk("sw_22_wecnt", r_wecnt, 0);
        chk("sw_22_ram", ram[8], 32'hDEADBEEF);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("rsv_size_err", {31'b0, r_err}, 32'd1);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h42; req_wdata = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        chk("rst_mid_write_we", {31'b0, mem_we}, 32'd1);
        chk("rst_mid_write_din", mem_din, 32'h12347788);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we_drop", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_ram", ram[16], 32'h55667788);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);

        @(negedge clk);
        nresp = 0;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            chk("b2b_ready", {31'b0, req_ready}, {31'b0, (i % 3) == 0});
            if (resp_valid) begin
                nresp++;
                chk("b2b_rdata", resp_rdata, 32'h80FF7F01);
            end
        end
        req_valid = 1'b0;
        chk("b2b_nresp", nresp, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
